// File: rtl/perspective_project_if.sv
// Vertex-in / divider / screen-out bundle for perspective_project.
// master: the projection block (drives ready, divider request, results).
// slave : the surroundings (vertex source, shared divider, rasteriser).
// Signals:
//   x_in, y_in, z_in, vertex_valid_in  camera vertex and its strobe
//   ready_out                          projection block idle
//   div_dividend_out, div_divisor_out  unsigned divide operands
//   div_valid_out                      one-cycle divide request
//   div_quotient_in, div_valid_in      divider result and its pulse
//   div_error_in, div_busy_in          divider status
//   sx_out, sy_out                     signed screen coordinates
//   on_screen_out, culled_out          visibility and rejection flags
//   valid_out                          one-cycle result pulse
interface perspective_project_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned PIX_WIDTH = 11
);
  logic [WIDTH-1:0]            x_in;
  logic [WIDTH-1:0]            y_in;
  logic [WIDTH-1:0]            z_in;
  logic                        vertex_valid_in;
  logic                        ready_out;
  logic [DIV_WIDTH-1:0]        div_dividend_out;
  logic [DIV_WIDTH-1:0]        div_divisor_out;
  logic                        div_valid_out;
  logic [DIV_WIDTH-1:0]        div_quotient_in;
  logic                        div_valid_in;
  logic                        div_error_in;
  logic                        div_busy_in;
  logic signed [PIX_WIDTH:0]   sx_out;
  logic signed [PIX_WIDTH:0]   sy_out;
  logic                        on_screen_out;
  logic                        culled_out;
  logic                        valid_out;

  modport master (
    input  x_in, y_in, z_in, vertex_valid_in,
    input  div_quotient_in, div_valid_in, div_error_in, div_busy_in,
    output ready_out, div_dividend_out, div_divisor_out, div_valid_out,
    output sx_out, sy_out, on_screen_out, culled_out, valid_out
  );

  modport slave (
    output x_in, y_in, z_in, vertex_valid_in,
    output div_quotient_in, div_valid_in, div_error_in, div_busy_in,
    input  ready_out, div_dividend_out, div_divisor_out, div_valid_out,
    input  sx_out, sy_out, on_screen_out, culled_out, valid_out
  );
endinterface

// File: rtl/perspective_project.sv
// Perspective projection front end for the shared iterative divider.
// Takes one camera-space vertex, issues |x|*FOCAL/z and |y|*FOCAL/z to the
// divider, then restores signs, recentres on the screen, saturates and
// flags visibility.
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-low reset (shared with the divider)
//   bus     perspective_project_if.master (vertex in, divider, result out)
module perspective_project #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned FOCAL     = 256,
  parameter int unsigned SCREEN_W  = 320,
  parameter int unsigned SCREEN_H  = 180,
  parameter int          NEAR      = 1,
  parameter int unsigned PIX_WIDTH = 11
) (
  input logic                   clk_in,
  input logic                   rst_in,
  perspective_project_if.master bus
);
  localparam int unsigned SHIFT  = $clog2(FOCAL);
  localparam int unsigned CALC_W = PIX_WIDTH + 3;
  localparam int unsigned PW1    = PIX_WIDTH + 1;
  localparam int unsigned PIX_MAX = 1 << PIX_WIDTH;
  localparam int          SAT_HI_I = (1 << PIX_WIDTH) - 1;
  localparam int          SAT_LO_I = -(1 << PIX_WIDTH);

  localparam logic signed [WIDTH-1:0]  NEAR_S = WIDTH'(NEAR);
  localparam logic signed [CALC_W-1:0] CX_S   = CALC_W'(SCREEN_W / 2);
  localparam logic signed [CALC_W-1:0] CY_S   = CALC_W'(SCREEN_H / 2);
  localparam logic signed [CALC_W-1:0] SAT_HI = CALC_W'(SAT_HI_I);
  localparam logic signed [CALC_W-1:0] SAT_LO = CALC_W'(SAT_LO_I);
  localparam logic signed [PW1-1:0]    SW_S   = PW1'(SCREEN_W);
  localparam logic signed [PW1-1:0]    SH_S   = PW1'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, DONE} state_t;

  state_t                   state, state_d;
  logic                     x_neg, x_neg_d, y_neg, y_neg_d;
  logic [WIDTH-1:0]         y_mag, y_mag_d;
  logic [DIV_WIDTH-1:0]     qx, qx_d;
  logic [DIV_WIDTH-1:0]     dividend, dividend_d, divisor, divisor_d;
  logic signed [PW1-1:0]    sx, sx_d, sy, sy_d;
  logic                     on_screen, on_screen_d, culled, culled_d;
  logic                     valid, valid_d, ready, ready_d;
  logic [WIDTH-1:0]         x_abs, y_abs;
  logic signed [PW1-1:0]    sx_sat, sy_sat;
  logic                     on_calc;

  // Clamp a quotient to 2^PIX_WIDTH and apply the vertex sign.
  function automatic logic signed [CALC_W-1:0] signed_offset(
    input logic [DIV_WIDTH-1:0] q, input logic neg);
    logic signed [CALC_W-1:0] mag;
    if (q > DIV_WIDTH'(PIX_MAX)) mag = CALC_W'(PIX_MAX);
    else                         mag = CALC_W'(q);
    return neg ? -mag : mag;
  endfunction

  // Saturate the widened coordinate into the signed pixel range.
  function automatic logic signed [PW1-1:0] saturate(input logic signed [CALC_W-1:0] v);
    if (v > SAT_HI)      return PW1'(SAT_HI);
    else if (v < SAT_LO) return PW1'(SAT_LO);
    else                 return PW1'(v);
  endfunction

  // Divide request is decoded live so a busy divider stalls the issue state.
  assign bus.div_valid_out    = ((state == ISSUE_X) || (state == ISSUE_Y)) && !bus.div_busy_in;
  assign bus.div_dividend_out = dividend;
  assign bus.div_divisor_out  = divisor;
  assign bus.ready_out        = ready;
  assign bus.sx_out           = sx;
  assign bus.sy_out           = sy;
  assign bus.on_screen_out    = on_screen;
  assign bus.culled_out       = culled;
  assign bus.valid_out        = valid;

  // State register and datapath registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      x_neg     <= 1'b0;
      y_neg     <= 1'b0;
      y_mag     <= '0;
      qx        <= '0;
      dividend  <= '0;
      divisor   <= '0;
      sx        <= '0;
      sy        <= '0;
      on_screen <= 1'b0;
      culled    <= 1'b0;
      valid     <= 1'b0;
      ready     <= 1'b1;
    end else begin
      state     <= state_d;
      x_neg     <= x_neg_d;
      y_neg     <= y_neg_d;
      y_mag     <= y_mag_d;
      qx        <= qx_d;
      dividend  <= dividend_d;
      divisor   <= divisor_d;
      sx        <= sx_d;
      sy        <= sy_d;
      on_screen <= on_screen_d;
      culled    <= culled_d;
      valid     <= valid_d;
      ready     <= ready_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state;
    x_neg_d     = x_neg;
    y_neg_d     = y_neg;
    y_mag_d     = y_mag;
    qx_d        = qx;
    dividend_d  = dividend;
    divisor_d   = divisor;
    sx_d        = sx;
    sy_d        = sy;
    on_screen_d = on_screen;
    culled_d    = culled;

    x_abs   = bus.x_in[WIDTH-1] ? (~bus.x_in + WIDTH'(1)) : bus.x_in;
    y_abs   = bus.y_in[WIDTH-1] ? (~bus.y_in + WIDTH'(1)) : bus.y_in;
    sx_sat  = saturate(CX_S + signed_offset(qx, x_neg));
    sy_sat  = saturate(CY_S - signed_offset(bus.div_quotient_in, y_neg));
    on_calc = !sx_sat[PIX_WIDTH] && (sx_sat < SW_S) && !sy_sat[PIX_WIDTH] && (sy_sat < SH_S);

    case (state)
      IDLE: begin
        if (bus.vertex_valid_in) begin
          x_neg_d = bus.x_in[WIDTH-1];
          y_neg_d = bus.y_in[WIDTH-1];
          y_mag_d = y_abs;
          if ($signed(bus.z_in) < NEAR_S) begin
            culled_d    = 1'b1;
            sx_d        = '0;
            sy_d        = '0;
            on_screen_d = 1'b0;
            state_d     = DONE;
          end else begin
            dividend_d = DIV_WIDTH'(x_abs) << SHIFT;
            divisor_d  = DIV_WIDTH'(bus.z_in);
            state_d    = ISSUE_X;
          end
        end
      end
      ISSUE_X: if (!bus.div_busy_in) state_d = WAIT_X;
      ISSUE_Y: if (!bus.div_busy_in) state_d = WAIT_Y;
      WAIT_X: begin
        if (bus.div_valid_in) begin
          if (bus.div_error_in) begin
            culled_d    = 1'b1;
            sx_d        = '0;
            sy_d        = '0;
            on_screen_d = 1'b0;
            state_d     = DONE;
          end else begin
            qx_d       = bus.div_quotient_in;
            dividend_d = DIV_WIDTH'(y_mag) << SHIFT;
            state_d    = ISSUE_Y;
          end
        end
      end
      WAIT_Y: begin
        if (bus.div_valid_in) begin
          if (bus.div_error_in) begin
            culled_d    = 1'b1;
            sx_d        = '0;
            sy_d        = '0;
            on_screen_d = 1'b0;
          end else begin
            culled_d    = 1'b0;
            sx_d        = sx_sat;
            sy_d        = sy_sat;
            on_screen_d = on_calc;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end
endmodule

// File: tb/tb_perspective_project.sv
// Scoreboard bench for perspective_project with a behavioural divider.
module tb_perspective_project;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  perspective_project_if bus();
  perspective_project dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));

  typedef struct {
    int sx; int sy; bit on; bit culled; bit chk_xy; bit near;
  } exp_t;
  typedef struct { int dividend; int divisor; } req_t;

  exp_t sb[$];
  req_t req_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   dv_cyc = -10;
  bit   err_next = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference: plain integer projection from the vertex, no RTL structure.
  task automatic expect_vertex(input int x, input int y, input int z, input bit err);
    exp_t e;
    int ax, ay, qx, qy;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    e.near = (z < 1);
    e.chk_xy = 1'b1; e.sx = 0; e.sy = 0; e.on = 1'b0; e.culled = 1'b1;
    if (!e.near) begin
      req_q.push_back('{ax * 256, z});
      if (err) e.chk_xy = 1'b0;
      else begin
        req_q.push_back('{ay * 256, z});
        qx = (ax * 256) / z; if (qx > 2048) qx = 2048;
        qy = (ay * 256) / z; if (qy > 2048) qy = 2048;
        e.sx = sat(160 + ((x < 0) ? -qx : qx));
        e.sy = sat(90 - ((y < 0) ? -qy : qy));
        e.on = (e.sx >= 0) && (e.sx < 320) && (e.sy >= 0) && (e.sy < 180);
        e.culled = 1'b0;
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every result pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("culled", int'(bus.culled_out), int'(e.culled));
          if (e.chk_xy) begin
            check("sx", int'($signed(bus.sx_out)), e.sx);
            check("sy", int'($signed(bus.sy_out)), e.sy);
            check("on_screen", int'(bus.on_screen_out), int'(e.on));
          end
          if (!e.near) check("result_latency", cyc, dv_cyc + 1);
        end
      end
    end
  end

  // Divider model: latency 2..5, optional busy stall before the second request.
  initial begin : divider
    bit pending, second, err;
    int cnt, hold, q;
    req_t r;
    pending = 0; second = 0; err = 0; cnt = 0; hold = 0; q = 0;
    bus.div_busy_in = 1'b0; bus.div_valid_in = 1'b0;
    bus.div_quotient_in = '0; bus.div_error_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.div_valid_in = 1'b0;
      bus.div_error_in = 1'b0;
      if (!rst_n) begin
        pending = 0; second = 0; hold = 0;
        bus.div_busy_in = 1'b0;
      end else begin
        if (pending) begin
          bus.div_busy_in = 1'b1;
          cnt--;
          if (cnt == 0) begin
            pending = 0;
            bus.div_busy_in = 1'b0;
            bus.div_valid_in = 1'b1;
            bus.div_error_in = err;
            bus.div_quotient_in = err ? '0 : 32'(q);
            dv_cyc = cyc;
            if (!second && !err) begin
              second = 1;
              hold = $urandom_range(0, 2);
            end else second = 0;
          end
        end else if (hold > 0) begin
          bus.div_busy_in = 1'b1;
          hold--;
        end else begin
          bus.div_busy_in = 1'b0;
        end
        #1;
        if (bus.div_valid_out === 1'b1) begin
          if (pending || bus.div_busy_in) check("div_request_while_busy", 1, 0);
          else if (req_q.size() == 0) check("unexpected_div_request", 1, 0);
          else begin
            r = req_q.pop_front();
            check("div_dividend", int'(bus.div_dividend_out), r.dividend);
            check("div_divisor", int'(bus.div_divisor_out), r.divisor);
            q = int'(bus.div_dividend_out) / int'(bus.div_divisor_out);
            err = err_next;
            err_next = 1'b0;
            pending = 1;
            cnt = $urandom_range(2, 5);
          end
        end
      end
    end
  end

  // Drive ignored junk while the block is not ready.
  task automatic drive_junk();
    if (!bus.ready_out) begin
      bus.vertex_valid_in = 1'($urandom_range(0, 1));
      bus.x_in = 16'($urandom);
      bus.y_in = 16'($urandom);
      bus.z_in = 16'($urandom);
    end else bus.vertex_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && req_q.size() == 0 && bus.ready_out) && n < 400) begin
      drive_junk();
      @(negedge clk);
      n++;
    end
    bus.vertex_valid_in = 1'b0;
    check("pending_expectations", sb.size() + req_q.size(), 0);
    sb.delete();
    req_q.delete();
  endtask

  task automatic present(input int x, input int y, input int z);
    int n;
    n = 0;
    while (!bus.ready_out && n < 400) begin
      drive_junk();
      @(negedge clk);
      n++;
    end
    if (!bus.ready_out) check("ready_timeout", 0, 1);
    bus.x_in = 16'(x);
    bus.y_in = 16'(y);
    bus.z_in = 16'(z);
    bus.vertex_valid_in = 1'b1;
  endtask

  task automatic send(input int x, input int y, input int z, input bit err);
    present(x, y, z);
    err_next = err;
    expect_vertex(x, y, z, err);
    @(negedge clk);
    bus.vertex_valid_in = 1'b0;
    if (z < 1) begin
      check("near_latency_valid", int'(bus.valid_out), 1);
      check("near_no_div_request", int'(bus.div_valid_out), 0);
    end else check("issue_latency", int'(bus.div_valid_out), 1);
    wait_idle();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int x, y, z;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0; bus.vertex_valid_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(bus.ready_out), 1);
    check("reset_valid", int'(bus.valid_out), 0);
    check("reset_div_valid", int'(bus.div_valid_out), 0);
    check("reset_sx", int'($signed(bus.sx_out)), 0);
    check("reset_culled", int'(bus.culled_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(100, 50, 512, 0);
    send(-100, -50, 512, 0);
    send(100, 50, 0, 0);
    send(100, 50, -5, 0);
    send(32767, 0, 1, 0);
    send(1000, 0, 256, 0);
    send(100, 50, 512, 1);
    send(-32768, 32767, 3, 0);

    // Reset while waiting on the first quotient.
    present(100, 50, 512);
    req_q.push_back('{25600, 512});
    @(negedge clk);
    bus.vertex_valid_in = 1'b0;
    check("reset_test_issue", int'(bus.div_valid_out), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_q.delete();
    check("ready_after_reset", int'(bus.ready_out), 1);
    check("valid_after_reset", int'(bus.valid_out), 0);
    repeat (10) @(negedge clk);
    send(100, 50, 512, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = $urandom_range(0, 2000) - 1000;
        y = $urandom_range(0, 600) - 300;
      end else begin
        x = $urandom_range(0, 65535) - 32768;
        y = $urandom_range(0, 65535) - 32768;
      end
      case ($urandom_range(0, 3))
        0:       z = $urandom_range(0, 12) - 6;
        1:       z = $urandom_range(1, 16);
        default: z = $urandom_range(1, 32767);
      endcase
      send(x, y, z, ($urandom_range(0, 9) == 0));
    end

    repeat (5) @(negedge clk);
    check("final_queues_empty", sb.size() + req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/perspective_project.md
Name: perspective_project

Overview:
- Upstream feeder for the shared iterative divider in the 3D pipeline.
- Accepts one camera-space vertex (signed x, y, z) and performs perspective projection: sx = CX + x*FOCAL/z, sy = CY - y*FOCAL/z.
- Issues two serial unsigned divisions through the divider's dividend/divisor/valid/busy handshake, then reapplies signs, recentres, clamps and flags screen visibility for the rasteriser.

Parameters:
WIDTH, 16, signed vertex coordinate width (x, y, z)
DIV_WIDTH, 32, divider operand width; must be >= WIDTH + log2(FOCAL)
FOCAL, 256, focal scale; power of two, applied as left shift
SCREEN_W, 320, screen width in pixels; CX = SCREEN_W/2
SCREEN_H, 180, screen height in pixels; CY = SCREEN_H/2
NEAR, 1, minimum accepted z; z < NEAR is culled
PIX_WIDTH, 11, magnitude bits of the screen coordinate

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-low reset
x_in  input  WIDTH  signed camera x
y_in  input  WIDTH  signed camera y
z_in  input  WIDTH  signed camera depth
vertex_valid_in  input  1  vertex present; accepted when ready_out=1
ready_out  output  1  high only in IDLE
div_dividend_out  output  DIV_WIDTH  unsigned numerator to divider
div_divisor_out  output  DIV_WIDTH  unsigned z to divider
div_valid_out  output  1  one-cycle divide request
div_quotient_in  input  DIV_WIDTH  divider quotient
div_valid_in  input  1  divider result pulse
div_error_in  input  1  divider divide-by-zero flag
div_busy_in  input  1  divider busy
sx_out  output  PIX_WIDTH+1  signed screen x
sy_out  output  PIX_WIDTH+1  signed screen y
on_screen_out  output  1  0<=sx<SCREEN_W and 0<=sy<SCREEN_H
culled_out  output  1  vertex rejected (near plane or divider error)
valid_out  output  1  one-cycle result pulse

Behaviour:
- Reset (rst_in=0 at a clock edge): state IDLE; ready_out=1; all other outputs 0. Reset mid-operation aborts, drops the vertex, and emits no valid_out. The divider shares rst_in.
- States: IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, DONE.
- IDLE:
  - On vertex_valid_in, latch x/y/z plus sign bits and magnitudes |x|, |y|.
  - If z < NEAR (includes z<=0): set culled_out=1, sx_out=sy_out=0, on_screen_out=0; go to DONE. No divider request is issued.
  - Otherwise go to ISSUE_X.
- ISSUE_X / ISSUE_Y:
  - When div_busy_in=0, assert div_valid_out for exactly one cycle. Dividend = |x| << log2(FOCAL) (resp. |y|), zero-extended to DIV_WIDTH. Divisor = z zero-extended.
  - Advance to WAIT_X / WAIT_Y.
  - If div_busy_in=1, hold with div_valid_out=0.
- WAIT_X / WAIT_Y:
  - Ignore all divider inputs until div_valid_in=1.
  - On div_valid_in, capture the quotient. If div_error_in=1, set culled and go to DONE.
  - Otherwise WAIT_X goes to ISSUE_Y and WAIT_Y goes to DONE.
- Arithmetic (done on the WAIT_Y exit edge):
  - Clamp each quotient to 2^PIX_WIDTH before sign application.
  - sx = CX + (x<0 ? -qx : qx); sy = CY - (y<0 ? -qy : qy).
  - Compute in PIX_WIDTH+3 bits, then saturate to [-(2^PIX_WIDTH), 2^PIX_WIDTH - 1].
  - on_screen_out is derived from the saturated values.
- DONE: valid_out=1 for one cycle; outputs are registered and held until the next DONE; next state IDLE.
- Latency: vertex accepted at T.
  - Non-culled: div_valid_out at T+1 (divider idle); valid_out one cycle after the second div_valid_in.
  - Near-culled: valid_out at T+1.
- Throughput: one vertex in flight; vertex_valid_in is ignored outside IDLE. Back-to-back acceptance is possible in the cycle after valid_out.

Test Plan:
- x=100, y=50, z=512 (defaults) -> divider sees 25600/512 then 12800/512; sx=210, sy=65, on_screen=1, culled=0, exactly two div_valid_out pulses.
- x=-100, y=-50, z=512 -> sx=110, sy=115, on_screen=1.
- z=0, and separately z=-5 -> valid_out at T+1, culled=1, sx=sy=0, no div_valid_out.
- x=32767, y=0, z=1 -> qx clamps; sx=2047, sy=90, on_screen=0. Also x=1000, z=256 -> sx=1160, on_screen=0.
- Force div_error_in=1 with first div_valid_in -> culled=1, valid_out pulse, no second request.
- Drive rst_in=0 for one cycle during WAIT_X, then release -> ready_out=1, no valid_out. A fresh vertex (x=100, y=50, z=512) then yields sx=210, sy=65.
